// File: rtl/clk_div_n_detector_if.sv
// clk_div_n_detector_if: divided-clock input and measurement results.
// master drives the divided clock, slave is the detector.
interface clk_div_n_detector_if #(
  parameter int W = 8
);
  logic         clk_div_in;
  logic [W-1:0] n_out;
  logic [W-1:0] high_out;
  logic         meas_valid;
  logic         locked;
  logic         timeout;

  modport master (
    output clk_div_in,
    input  n_out,
    input  high_out,
    input  meas_valid,
    input  locked,
    input  timeout
  );

  modport slave (
    input  clk_div_in,
    output n_out,
    output high_out,
    output meas_valid,
    output locked,
    output timeout
  );
endinterface

// File: rtl/clk_div_n_detector.sv
// clk_div_n_detector: measures period N and high time of a divided clock.
// Define CLK_DIV_DET_SYNC_EN to add a 2-flop input synchronizer.
module clk_div_n_detector #(
  parameter int W        = 8,
  parameter int LOCK_CNT = 2
) (
  input logic                 clk,
  input logic                 rst,
  clk_div_n_detector_if.slave bus
);

  typedef enum logic {
    IDLE,
    MEAS
  } state_t;

  localparam logic [W-1:0] MAX = '1;
  localparam logic [3:0] LOCK_TH = 4'(LOCK_CNT - 1);

  state_t state;
  state_t state_nx;

  logic src;
  logic s;
  logic s_d;
  logic rise;

  logic [W-1:0] period_cnt;
  logic [W-1:0] high_cnt;
  logic [W-1:0] n_q;
  logic [W-1:0] high_q;
  logic         valid_q;
  logic         lock_q;
  logic         to_q;
  logic         fresh;
  logic [3:0]   match_cnt;
  logic [3:0]   match_nx;
  logic         lock_nx;
  logic         same;

  logic start;
  logic done;
  logic expire;
  logic count;

`ifdef CLK_DIV_DET_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], bus.clk_div_in};
    end
  end

  assign src = sync[1];
`else
  assign src = bus.clk_div_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s   <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s   <= src;
      s_d <= s;
    end
  end

  assign rise = s & ~s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nx = MEAS;
        end
      end
      MEAS: begin
        if (!rise && period_cnt == MAX) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A rise always beats the timeout on the same cycle.
  always_comb begin
    start  = 1'b0;
    done   = 1'b0;
    expire = 1'b0;
    count  = 1'b0;
    if (state == MEAS) begin
      priority case (1'b1)
        rise:              done   = 1'b1;
        period_cnt == MAX: expire = 1'b1;
        default:           count  = 1'b1;
      endcase
    end else begin
      start = rise;
    end
  end

  // The first period after arming never matches, so it cannot lock alone.
  assign same = !fresh && (period_cnt == n_q);

  always_comb begin
    match_nx = 4'd0;
    if (same) begin
      match_nx = (match_cnt == 4'd15) ? 4'd15 : match_cnt + 4'd1;
    end
  end

  assign lock_nx = (match_nx >= LOCK_TH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      n_q        <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      lock_q     <= 1'b0;
      to_q       <= 1'b0;
      fresh      <= 1'b0;
      match_cnt  <= '0;
    end else begin
      valid_q <= done;
      to_q    <= expire;
      if (start || done) begin
        period_cnt <= W'(1);
        high_cnt   <= W'(1);
      end else if (count) begin
        period_cnt <= period_cnt + W'(1);
        high_cnt   <= high_cnt + W'(s);
      end else if (expire) begin
        period_cnt <= '0;
        high_cnt   <= '0;
      end
      if (start) begin
        fresh <= 1'b1;
      end
      if (done) begin
        n_q       <= period_cnt;
        high_q    <= high_cnt;
        match_cnt <= match_nx;
        lock_q    <= lock_nx;
        fresh     <= 1'b0;
      end
      if (expire) begin
        match_cnt <= '0;
        lock_q    <= 1'b0;
      end
    end
  end

  assign bus.n_out      = n_q;
  assign bus.high_out   = high_q;
  assign bus.meas_valid = valid_q;
  assign bus.locked     = lock_q;
  assign bus.timeout    = to_q;

endmodule

// File: tb/tb_clk_div_n_detector.sv
// tb_clk_div_n_detector: directed stimulus with a scoreboard queue of
// expected measurement and timeout events.
module tb_clk_div_n_detector;

  localparam int W        = 8;
  localparam int LOCK_CNT = 2;
  localparam int MAXP     = (1 << W) - 1;
`ifdef CLK_DIV_DET_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    bit is_to;
    int n;
    int h;
    bit lk;
    int gap;
    int cyc;
  } item_t;

  logic clk;
  logic rst;
  int   cyc;

  clk_div_n_detector_if #(.W(W)) dif ();

  clk_div_n_detector #(
    .W(W),
    .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  item_t q[$];
  int n_chk;
  int n_pass;
  int n_fail;

  bit   armed;
  bit   m_first;
  bit   prev_closed;
  logic last_bit;
  int   since;
  int   hi;
  int   m_prev;
  int   m_prev_h;
  int   m_match;
  int   last_mv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    armed       = 1'b0;
    m_first     = 1'b0;
    prev_closed = 1'b0;
    last_bit    = 1'b0;
    since       = 0;
    hi          = 0;
    m_prev      = 0;
    m_prev_h    = 0;
    m_match     = 0;
  endtask

  task automatic drive_bit(input logic b);
    item_t it;
    @(negedge clk);
    dif.clk_div_in = b;
    if (b && !last_bit) begin
      if (armed) begin
        if (m_first) m_match = 0;
        else if (since == m_prev) m_match = (m_match == 15) ? 15 : m_match + 1;
        else m_match = 0;
        it.is_to = 1'b0;
        it.n     = since;
        it.h     = hi;
        it.lk    = (m_match >= LOCK_CNT - 1);
        it.gap   = prev_closed ? since : -1;
        it.cyc   = cyc;
        q.push_back(it);
        m_prev      = since;
        m_prev_h    = hi;
        m_first     = 1'b0;
        prev_closed = 1'b1;
      end else begin
        armed       = 1'b1;
        m_first     = 1'b1;
        prev_closed = 1'b0;
      end
      since = 1;
      hi    = 1;
    end else if (armed && since == MAXP) begin
      it.is_to = 1'b1;
      it.n     = m_prev;
      it.h     = m_prev_h;
      it.lk    = 1'b0;
      it.gap   = prev_closed ? MAXP : -1;
      it.cyc   = cyc;
      q.push_back(it);
      armed       = 1'b0;
      m_match     = 0;
      prev_closed = 1'b0;
    end else begin
      since = since + 1;
      hi    = hi + int'(b);
    end
    last_bit = b;
  endtask

  task automatic drive_period(input int n, input int h);
    for (int i = 0; i < n; i++) drive_bit(i < h);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_n"}, 32'(dif.n_out), 0);
    check({tag, "_high"}, 32'(dif.high_out), 0);
    check({tag, "_valid"}, 32'(dif.meas_valid), 0);
    check({tag, "_locked"}, 32'(dif.locked), 0);
    check({tag, "_timeout"}, 32'(dif.timeout), 0);
  endtask

  always @(negedge clk) begin
    item_t it;
    if (!rst && (dif.meas_valid || dif.timeout)) begin
      check("event_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        it = q.pop_front();
        check("event_kind", 32'(dif.timeout), 32'(it.is_to));
        check("n_out", 32'(dif.n_out), it.n);
        check("high_out", 32'(dif.high_out), it.h);
        check("locked", 32'(dif.locked), 32'(it.lk));
        check("latency", cyc - it.cyc, LAT);
        if (it.gap >= 0) check("spacing", cyc - last_mv, it.gap);
      end
      if (dif.meas_valid) last_mv = cyc;
    end
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    n_fail = 0;
    last_mv = 0;
    model_clear();
    rst = 1'b1;
    dif.clk_div_in = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    repeat (6) drive_period(2, 1);
    repeat (4) drive_period(3, 1);
    repeat (4) drive_period(4, 2);
    repeat (4) drive_period(5, 2);
    repeat (4) drive_period(8, 4);

    repeat (4) drive_period(4, 2);
    repeat (3) drive_period(5, 2);

    repeat (4) drive_period(4, 2);
    repeat (300) drive_bit(1'b0);
    check("idle_locked", 32'(dif.locked), 0);
    check("idle_n_kept", 32'(dif.n_out), 4);
    check("idle_q_drained", q.size(), 0);

    repeat (4) drive_period(4, 2);

    repeat (3) drive_period(8, 4);
    for (int i = 0; i < 5; i++) drive_bit(i < 4);
    check("pre_reset_q", q.size(), 0);
    rst = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_zero("mid_reset");
    end
    rst = 1'b0;
    repeat (2) drive_bit(1'b0);
    repeat (4) drive_period(8, 4);

    repeat (3) drive_period(MAXP, 1);
    repeat (3) drive_period(2, 1);
    repeat (300) drive_bit(1'b0);

    check("final_q_drained", q.size(), 0);
    check("final_locked", 32'(dif.locked), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
